// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, phase encoding and debug view for the
// horizontal and vertical VGA generators.
package vga_timing_pkg;

    // Horizontal timing in 50 MHz clocks
    localparam int H_PULSE = 192;
    localparam int H_BACK  = 96;
    localparam int H_DISP  = 1280;
    localparam int H_FRONT = 32;
    localparam int PIX_DIV = 10;
    localparam int H_COLS  = 128;
    localparam int H_LINE  = H_PULSE + H_BACK + H_DISP + H_FRONT;
    localparam int H_CNT_W = 11;

    // Vertical timing in lines; 96 rows of 5 lines each
    localparam int V_PULSE = 2;
    localparam int V_BACK  = 33;
    localparam int V_DISP  = 480;
    localparam int V_FRONT = 10;
    localparam int V_FRAME = V_PULSE + V_BACK + V_DISP + V_FRONT;
    localparam int V_DIV   = 5;
    localparam int V_ROWS  = 96;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        BACK  = 2'd1,
        DISP  = 2'd2,
        FRONT = 2'd3
    } phase_t;

    typedef struct packed {
        phase_t               state;
        logic [H_CNT_W-1:0]   h_cnt;
        logic [3:0]           div_cnt;
    } hsync_dbg_t;

endpackage

// File: rtl/hsync_pixdiv.sv
// Generic divide-by-DIV column counter: div_cnt counts 0..DIV-1 while enabled,
// col steps on each wrap and saturates at COLS-1. clr has priority over en.
module hsync_pixdiv #(
    parameter int DIV   = 10,
    parameter int COLS  = 128,
    parameter int DIV_W = 4,
    parameter int COL_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [DIV_W-1:0] div_cnt,
    output logic [COL_W-1:0] col
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        col_d     = col_q;
        if (clr) begin
            div_cnt_d = '0;
            col_d     = '0;
        end else if (en) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                if (col_q != COL_LAST) begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            col_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            col_q     <= col_d;
        end
    end

    assign div_cnt = div_cnt_q;
    assign col     = col_q;

endmodule

// File: rtl/hsync.sv
// Horizontal VGA timing generator: line counter, SYNC/BACK/DISP/FRONT phase FSM,
// end-of-line strobe and column index. DISPLAY_EN exists only with HSYNC_DE_EN.
module hsync #(
    parameter int H_PULSE = vga_timing_pkg::H_PULSE,
    parameter int H_BACK  = vga_timing_pkg::H_BACK,
    parameter int H_DISP  = vga_timing_pkg::H_DISP,
    parameter int H_FRONT = vga_timing_pkg::H_FRONT,
    parameter int PIX_DIV = vga_timing_pkg::PIX_DIV,
    parameter int H_COLS  = vga_timing_pkg::H_COLS
) (
    input  logic       clk,
    input  logic       reset,
    output logic       VGA_HSYNC,
    output logic       RGB_HSYNC,
    output logic [6:0] HPIXEL
`ifdef HSYNC_DE_EN
    ,
    output logic       DISPLAY_EN
`endif
);

    import vga_timing_pkg::*;

    localparam int L = H_PULSE + H_BACK + H_DISP + H_FRONT;

    // Last h_cnt value of each phase; a phase ends on the clock its value is seen
    localparam logic [H_CNT_W-1:0] SYNC_LAST = H_CNT_W'(H_PULSE - 1);
    localparam logic [H_CNT_W-1:0] BACK_LAST = H_CNT_W'(H_PULSE + H_BACK - 1);
    localparam logic [H_CNT_W-1:0] DISP_LAST = H_CNT_W'(H_PULSE + H_BACK + H_DISP - 1);
    localparam logic [H_CNT_W-1:0] LINE_LAST = H_CNT_W'(L - 1);

    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    phase_t             state_q, state_d;
    logic               hsync_n_q, hsync_n_d;
    logic               rgb_q, rgb_d;
    logic               pix_en, pix_clr;
    logic [3:0]         div_cnt;
    logic [6:0]         col;

    always_comb begin
        h_cnt_d = (h_cnt_q == LINE_LAST) ? '0 : h_cnt_q + 1'b1;
        state_d = state_q;
        case (state_q)
            SYNC:    if (h_cnt_q == SYNC_LAST) state_d = BACK;
            BACK:    if (h_cnt_q == BACK_LAST) state_d = DISP;
            DISP:    if (h_cnt_q == DISP_LAST) state_d = FRONT;
            FRONT:   if (h_cnt_q == LINE_LAST) state_d = SYNC;
            default: state_d = SYNC;
        endcase
        // Outputs are registered from next-state values so they line up with h_cnt_q
        hsync_n_d = (state_d != SYNC);
        rgb_d     = (h_cnt_d == LINE_LAST);
        pix_clr   = (state_d != DISP) || (state_q != DISP);
        pix_en    = (state_q == DISP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q   <= '0;
            state_q   <= SYNC;
            hsync_n_q <= 1'b0;
            rgb_q     <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            state_q   <= state_d;
            hsync_n_q <= hsync_n_d;
            rgb_q     <= rgb_d;
        end
    end

    hsync_pixdiv #(
        .DIV   (PIX_DIV),
        .COLS  (H_COLS),
        .DIV_W (4),
        .COL_W (7)
    ) u_pixdiv (
        .clk     (clk),
        .rst_n   (reset),
        .en      (pix_en),
        .clr     (pix_clr),
        .div_cnt (div_cnt),
        .col     (col)
    );

    // Debug view of the FSM and counters for bound checkers
    hsync_dbg_t hsync_dbg;
    logic       unused_dbg;
    assign hsync_dbg  = '{state: state_q, h_cnt: h_cnt_q, div_cnt: div_cnt};
    assign unused_dbg = ^hsync_dbg;

    assign VGA_HSYNC = hsync_n_q;
    assign RGB_HSYNC = rgb_q;
    assign HPIXEL    = col;

`ifdef HSYNC_DE_EN
    logic de_q, de_d;

    always_comb begin
        de_d = (state_d == DISP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q <= 1'b0;
        end else begin
            de_q <= de_d;
        end
    end

    assign DISPLAY_EN = de_q;
`endif

endmodule

// File: doc/hsync.md
# hsync

Horizontal timing generator for the 640x480@60 VGA path on the 50 MHz system clock. It counts 1600 clocks per scanline and drives the active-low VGA_HSYNC pin. It emits the one-clock RGB_HSYNC line strobe that the downstream vertical generator uses to advance its line count. It also produces the 7-bit HPIXEL column index (128 columns, 10 clocks each) that addresses the frame buffer together with VPIXEL.

## Interface
Parameters:
- H_PULSE, 192, sync pulse width in clocks
- H_BACK, 96, back porch in clocks
- H_DISP, 1280, active display in clocks
- H_FRONT, 32, front porch in clocks
- PIX_DIV, 10, clocks per HPIXEL column
- H_COLS, 128, columns per line; PIX_DIV*H_COLS must equal H_DISP

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low reset
- VGA_HSYNC  output  1  horizontal sync to the connector, active low
- RGB_HSYNC  output  1  one-clock end-of-line strobe to the vertical generator
- HPIXEL  output  7  active column index, 0..H_COLS-1
- DISPLAY_EN  output  1  high during the active display window; present only with HSYNC_DE_EN

## Operation
- h_cnt is an 11-bit line counter, 0..L-1 with L = H_PULSE+H_BACK+H_DISP+H_FRONT (1600). It wraps to 0 after L-1. The sum L must not exceed 2048.
- The FSM runs SYNC -> BACK -> DISP -> FRONT -> SYNC. Each transition happens on the last clock of its phase, derived from h_cnt:
  - SYNC: h_cnt 0..191
  - BACK: 192..287
  - DISP: 288..1567
  - FRONT: 1568..1599
- VGA_HSYNC = 0 exactly while in SYNC, 1 otherwise. Decode it from the registered state, with no glitches.
- RGB_HSYNC = 1 for exactly one clock, when h_cnt == L-1 (the last FRONT clock). It is 0 on every other clock.
- Pixel divider: a 4-bit div_cnt counts 0..PIX_DIV-1 and only runs in DISP.
  - On entry to DISP, div_cnt = 0 and HPIXEL = 0.
  - When div_cnt == PIX_DIV-1: div_cnt -> 0 and HPIXEL increments.
  - On the last DISP clock, HPIXEL does not advance past H_COLS-1.
- Outside DISP, HPIXEL is held at 0 and div_cnt at 0.
- In DISP clock d (0..1279 from the start of DISP), HPIXEL == d / PIX_DIV, using integer division.
- Reset asserted, including mid-line:
  - h_cnt = 0, state = SYNC, div_cnt = 0
  - HPIXEL = 0, RGB_HSYNC = 0, VGA_HSYNC = 0, DISPLAY_EN = 0
- On reset release, the first clock edge starts line cycle 1. No partial strobe is issued for the aborted line.

## Timing
- All state is registered on posedge clk. Reset acts on negedge reset, asynchronously.
- HPIXEL, RGB_HSYNC and DISPLAY_EN have zero additional latency: they reflect the current h_cnt cycle.
- Line period is L clocks, 32 µs at 50 MHz. The RGB_HSYNC period is exactly L.
- VGA_HSYNC low width is H_PULSE clocks, starting on the clock after the RGB_HSYNC strobe.
- HPIXEL steps every PIX_DIV clocks: 128 increments of 10 clocks each across the 1280-clock window.

## Configuration
- HSYNC_DE_EN defined: the DISPLAY_EN port exists and equals (state == DISP), registered alongside HPIXEL.
- HSYNC_DE_EN undefined: the port and its logic are absent. Downstream consumers derive blanking from VPIXEL/HPIXEL timing on their own.
- Timing, strobe and HPIXEL behaviour are identical either way.

## Structure
- Shared package vga_timing_pkg holds:
  - the 640x480 constants H_PULSE, H_BACK, H_DISP, H_FRONT, PIX_DIV, H_COLS, and the line length
  - the phase state encoding (SYNC, BACK, DISP, FRONT)
  - the V-side counterparts (525 lines, 96 rows x 5 lines)
- One sub-module: hsync_pixdiv. It is a generic divide-by-PIX_DIV column counter with enable and clear inputs, producing div_cnt and HPIXEL. The vertical side can reuse it.

## Test plan
- Reset released, run 3 lines -> RGB_HSYNC pulses at 1600-clock spacing. The first pulse comes 1599 clocks after the first edge, each 1 clock wide.
- Measure VGA_HSYNC -> low for exactly 192 clocks starting 1 clock after each strobe, high for 1408.
- Sample HPIXEL across DISP -> 0 for DISP clocks 0..9, 1 for 10..19, …, 127 for 1270..1279, then 0 in FRONT/SYNC/BACK.
- Assert reset at h_cnt == 900 for 3 clocks, then release:
  - During reset, all outputs are at their reset values immediately, without waiting for a clock.
  - The next RGB_HSYNC comes 1599 clocks after release.
- With HSYNC_DE_EN defined -> DISPLAY_EN high for exactly 1280 clocks per line, aligned with HPIXEL 0..127. Without it -> the build succeeds with no DISPLAY_EN port.
- Connect to the vertical generator and run 525 lines -> the vertical counter wraps once and VPIXEL cycles 0..95.
